adder_operand_sequencer: RTL and testbench
==========================================

// Module: adder_operand_sequencer
// PURPOSE
//  Upstream stage for the 4-bit ripple-carry adder. Captures operands A, B and carry-in
//  one nibble at a time from the switches on debounced load presses.
//  Drives the adder's 9-bit operand bus, waits a fixed settle time, then registers and
//  holds the 5-bit sum for the LEDs.
//  Optional accumulate mode chains each result back in as the next A.
// PARAMETERS
//  WIDTH          4  operand width; the adder sum is WIDTH+1 bits
//  SETTLE_CYCLES  2  clocks allowed for the ripple chain before the sum is sampled (>=1)
// PORTS
//  clk          in   1          system clock; all state on rising edge
//  resetn       in   1          asynchronous, active-low reset
//  data_in      in   WIDTH      operand nibble from switches
//  cin_in       in   1          carry-in, captured together with A
//  load         in   1          active-high load request (asynchronous key); rising edge counts
//  clear        in   1          synchronous clear, active-high
//  acc_mode     in   1          1 = accumulate: the next load after DONE supplies only B
//  operand_bus  out  2*WIDTH+1  {cin, a, b} to adder (bit 8 = ci, [7:4] = a, [3:0] = b)
//  sum_in       in   WIDTH+1    adder output {co, s}
//  result       out  WIDTH+1    registered sum
//  result_valid out  1          result holds the sum of the current operands
//  busy         out  1          high in SETTLE; load edges are dropped
//  state        out  2          current FSM state (for LED debug)
// BEHAVIOUR
//  Reset (async, resetn=0): a_reg, b_reg, cin_reg, result, settle count, and sync flops = 0.
//   result_valid = 0, busy = 0, state = S_A, so operand_bus = 0.
//  Load path: 2-flop synchroniser, then rising-edge detect.
//   load_pulse is one cycle wide, 3 clk after load rises.
//   A level held high yields exactly one pulse.
//  FSM (encodings S_A=0, S_B=1, S_SETTLE=2, S_DONE=3):
//   S_A:      on load_pulse: a_reg<=data_in, cin_reg<=cin_in; go to S_B.
//   S_B:      on load_pulse: b_reg<=data_in, cnt<=SETTLE_CYCLES-1; go to S_SETTLE.
//   S_SETTLE: busy=1. If cnt==0: result<=sum_in, result_valid<=1, go to S_DONE.
//             Otherwise cnt<=cnt-1.
//   S_DONE:   result held. On load_pulse, result_valid<=0 in the same edge, then:
//             acc_mode=1: a_reg<=result[WIDTH-1:0], cin_reg<=result[WIDTH],
//               b_reg<=data_in, cnt reloaded; go to S_SETTLE.
//             acc_mode=0: a_reg<=data_in, cin_reg<=cin_in; go to S_B.
//  Latency: load_pulse in cycle t captures B. result_valid=1 from cycle t+SETTLE_CYCLES+1.
//  operand_bus is a direct concatenation of the registers; no combinational path from inputs.
//  clear: next edge forces S_A, zeroes registers, result_valid=0.
//   clear beats a simultaneous load_pulse.
//   clear during S_SETTLE aborts; no result is written.
//  load_pulse while in S_SETTLE: ignored, not queued.
//  Arithmetic is done by the adder only. result[WIDTH] is the adder carry-out.
//   The sum wraps modulo 2^(WIDTH+1); this block does no overflow handling.
//  acc_mode is sampled only on the S_DONE load_pulse; changing it elsewhere has no effect.
//  resetn low mid-operation: immediate return to the reset state. Partial operands are lost.
// STRUCTURE
//  Shared header adder_lab_defs.vh: S_A/S_B/S_SETTLE/S_DONE localparams, default WIDTH.
//  Sub-module key_sync_edge (clk, resetn, async_in, pulse_out): 2-flop sync + edge detect.
//   Reused for other key inputs.
//  Top: FSM, operand/result registers, settle counter of width $clog2(SETTLE_CYCLES+1).
// TESTING (bench instantiates this block driving the 4-bit ripple-carry adder)
//  1. Reset with inputs toggling -> all outputs 0, state=0. Release -> still S_A.
//  2. A=4'h5, cin=0, B=4'h3 -> operand_bus=9'h053. result=5'h08, result_valid=1,
//     exactly SETTLE_CYCLES+1 clk after the B pulse.
//  3. A=4'hF, cin=1, B=4'hF -> result=5'h1F. A=4'h9, cin=0, B=4'h7 -> result=5'h10 (carry out).
//  4. acc_mode=1: A=2, B=3 -> 5. Next B=4 -> 9. Next B=8 -> result=5'h11.
//     The next add uses a=1, cin=1 (B=0 gives 5'h02).
//  5. Load edges during SETTLE are ignored. A load held high for 50 clk gives one capture.
//     A load pulse narrower than 1 clk that lands between edges may be missed.
//  6. clear asserted in S_SETTLE together with load -> S_A next cycle.
//     result_valid stays 0 and result stays unchanged.

Source files
------------

// File: rtl/adder_operand_sequencer_pkg.sv
// Purpose: shared types and defaults for the adder operand sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adder_operand_sequencer_pkg;

    localparam int DEF_WIDTH         = 4;
    localparam int DEF_SETTLE_CYCLES = 2;

    // The encoding is visible on the debug LEDs, so the values are fixed.
    typedef enum logic [1:0] {
        S_A      = 2'd0,
        S_B      = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/adder_operand_sequencer_if.sv
// Purpose: bundles the switch/key inputs, the adder operand/sum bus and the LED outputs.
// Latency: n/a (wires only).
// Backpressure: none; busy only tells the operator that load presses are being dropped.
// Ports: master = operator + adder side (drives data_in, cin_in, load, clear, acc_mode, sum_in)
//        slave  = sequencer side (drives operand_bus, result, result_valid, busy, state)
interface adder_operand_sequencer_if
    import adder_operand_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] data_in;
    logic             cin_in;
    logic             load;
    logic             clear;
    logic             acc_mode;
    logic [2*WIDTH:0] operand_bus;
    logic [WIDTH:0]   sum_in;
    logic [WIDTH:0]   result;
    logic             result_valid;
    logic             busy;
    logic [1:0]       state;

    modport master (
        output data_in, cin_in, load, clear, acc_mode, sum_in,
        input  operand_bus, result, result_valid, busy, state
    );

    modport slave (
        input  data_in, cin_in, load, clear, acc_mode, sum_in,
        output operand_bus, result, result_valid, busy, state
    );
endinterface

// File: rtl/adder_operand_sequencer_key_sync.sv
// Purpose: key_sync_edge - 2-flop synchroniser plus rising-edge detect for a raw key input.
// Latency: pulse_out is high for one cycle, seen by the third clock edge after async_in rises.
// Backpressure: none; a level held high gives exactly one pulse.
// Ports: clk, resetn (async active-low), async_in (raw key), pulse_out (one-cycle pulse).
module key_sync_edge (
    input  logic clk,
    input  logic resetn,
    input  logic async_in,
    output logic pulse_out
);
    logic sync_1;
    logic sync_2;
    logic sync_prev;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_1    <= async_in;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    assign pulse_out = sync_2 & ~sync_prev;
endmodule

// File: rtl/adder_operand_sequencer.sv
// Purpose: captures A/cin and B from switches on load presses, drives the ripple adder,
//          waits SETTLE_CYCLES, then registers and holds the sum; optional accumulate mode.
// Latency: B captured on load pulse in cycle t; result_valid from cycle t+SETTLE_CYCLES+1.
// Backpressure: load pulses arriving while busy (S_SETTLE) are dropped, never queued.
// Ports: clk, resetn (async active-low), bus (slave modport of adder_operand_sequencer_if).
module adder_operand_sequencer
    import adder_operand_sequencer_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
)(
    input  logic                        clk,
    input  logic                        resetn,
    adder_operand_sequencer_if.slave    bus
);
    localparam int                CNT_W      = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    seq_state_t       state_q;
    seq_state_t       state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             cin_reg;
    logic [WIDTH:0]   result_reg;
    logic             result_vld;
    logic [CNT_W-1:0] cnt;
    logic             load_pulse;

    // Per-cycle control strobes decoded from the state
    logic cap_a;
    logic cap_b;
    logic acc_ld;
    logic leave_done;
    logic settle_done;

    key_sync_edge u_load_sync (
        .clk       (clk),
        .resetn    (resetn),
        .async_in  (bus.load),
        .pulse_out (load_pulse)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_A;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic; clear wins over any simultaneous load pulse
    always_comb begin
        state_nxt = state_q;
        if (bus.clear) begin
            state_nxt = S_A;
        end else begin
            case (state_q)
                S_A:      if (load_pulse) state_nxt = S_B;
                S_B:      if (load_pulse) state_nxt = S_SETTLE;
                S_SETTLE: if (cnt == '0)  state_nxt = S_DONE;
                S_DONE:   if (load_pulse) state_nxt = bus.acc_mode ? S_SETTLE : S_B;
                default:  state_nxt = S_A;
            endcase
        end
    end

    // Output / strobe decode
    always_comb begin
        cap_a       = 1'b0;
        cap_b       = 1'b0;
        acc_ld      = 1'b0;
        leave_done  = 1'b0;
        settle_done = 1'b0;
        if (!bus.clear) begin
            case (state_q)
                S_A:      cap_a = load_pulse;
                S_B:      cap_b = load_pulse;
                S_SETTLE: settle_done = (cnt == '0);
                S_DONE: begin
                    leave_done = load_pulse;
                    acc_ld     = load_pulse & bus.acc_mode;
                    cap_a      = load_pulse & ~bus.acc_mode;
                end
                default: ;
            endcase
        end
    end

    // Operand, counter and result registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_reg      <= '0;
            b_reg      <= '0;
            cin_reg    <= 1'b0;
            cnt        <= '0;
            result_reg <= '0;
            result_vld <= 1'b0;
        end else if (bus.clear) begin
            // The held result is kept so an aborted add leaves the LEDs unchanged.
            a_reg      <= '0;
            b_reg      <= '0;
            cin_reg    <= 1'b0;
            cnt        <= '0;
            result_vld <= 1'b0;
        end else begin
            if (cap_a) begin
                a_reg   <= bus.data_in;
                cin_reg <= bus.cin_in;
            end
            if (cap_b) begin
                b_reg <= bus.data_in;
                cnt   <= CNT_RELOAD;
            end
            if (acc_ld) begin
                // Chain the previous sum back in: low bits become A, carry-out becomes cin.
                a_reg   <= result_reg[WIDTH-1:0];
                cin_reg <= result_reg[WIDTH];
                b_reg   <= bus.data_in;
                cnt     <= CNT_RELOAD;
            end
            if (leave_done) begin
                result_vld <= 1'b0;
            end
            if (state_q == S_SETTLE && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (settle_done) begin
                result_reg <= bus.sum_in;
                result_vld <= 1'b1;
            end
        end
    end

    assign bus.operand_bus  = {cin_reg, a_reg, b_reg};
    assign bus.result       = result_reg;
    assign bus.result_valid = result_vld;
    assign bus.busy         = (state_q == S_SETTLE);
    assign bus.state        = state_q;
endmodule

// File: tb/tb_adder_operand_sequencer.sv
module tb_adder_operand_sequencer;
    localparam int W      = 4;
    localparam int SETTLE = 2;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    adder_operand_sequencer_if #(.WIDTH(W)) aif ();

    adder_operand_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SETTLE)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (aif)
    );

    // Behavioural 4-bit adder on the operand bus
    assign aif.sum_in = {1'b0, aif.operand_bus[7:4]} + {1'b0, aif.operand_bus[3:0]}
                      + {4'b0, aif.operand_bus[8]};

    int vectors    = 0;
    int miscompares = 0;

    // Reference model at operation level: which operand is expected next and the held result
    int m_phase;   // 0: next load is A, 1: next load is B, 2: result held
    int m_a, m_b, m_c, m_res, m_valid;

    typedef struct {
        logic [3:0] a;
        logic       cin;
        logic [3:0] b;
        logic [8:0] exp_bus;
        logic [4:0] exp_res;
    } vec_t;

    vec_t tbl [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_state();
        return (m_phase == 0) ? 0 : (m_phase == 1) ? 1 : 3;
    endfunction

    task automatic model_load(input int d, input int c, input int acc);
        case (m_phase)
            0: begin m_a = d; m_c = c; m_phase = 1; end
            1: begin m_b = d; m_res = (m_a + m_b + m_c) % 32; m_valid = 1; m_phase = 2; end
            default: begin
                if (acc != 0) begin
                    m_a = m_res % 16; m_c = m_res / 16; m_b = d;
                    m_res = (m_a + m_b + m_c) % 32; m_valid = 1;
                end else begin
                    m_a = d; m_c = c; m_valid = 0; m_phase = 1;
                end
            end
        endcase
    endtask

    task automatic model_clear();
        m_phase = 0; m_a = 0; m_b = 0; m_c = 0; m_valid = 0;
    endtask

    task automatic compare_all(input string name);
        check({name, ".bus"},   32'(aif.operand_bus), 32'(m_c * 256 + m_a * 16 + m_b));
        check({name, ".res"},   32'(aif.result),       32'(m_res));
        check({name, ".vld"},   32'(aif.result_valid), 32'(m_valid));
        check({name, ".state"}, 32'(aif.state),        32'(exp_state()));
        check({name, ".busy"},  32'(aif.busy),         32'd0);
    endtask

    // One load press held for SETTLE+3 clocks; checks result timing when a sum is produced
    task automatic do_load(input int d, input int c, input int acc, input string name);
        bit produces;
        produces = (m_phase == 1) || (m_phase == 2 && acc != 0);
        @(negedge clk);
        aif.data_in  = 4'(d);
        aif.cin_in   = 1'(c);
        aif.acc_mode = 1'(acc);
        aif.load     = 1'b1;
        for (int k = 1; k <= SETTLE + 3; k++) begin
            @(negedge clk);
            if (produces) begin
                if (k == 3)          check({name, ".busy_on"}, 32'(aif.busy), 32'd1);
                if (k == SETTLE + 2) check({name, ".vld_early"}, 32'(aif.result_valid), 32'd0);
                if (k == SETTLE + 3) check({name, ".vld_on_time"}, 32'(aif.result_valid), 32'd1);
            end
        end
        aif.load = 1'b0;
        repeat (4) @(negedge clk);
        model_load(d, c, acc);
        compare_all(name);
    endtask

    initial begin
        logic [31:0] held_res;
        aif.data_in = '0; aif.cin_in = 1'b0; aif.load = 1'b0;
        aif.clear = 1'b0; aif.acc_mode = 1'b0;
        m_phase = 0; m_a = 0; m_b = 0; m_c = 0; m_res = 0; m_valid = 0;

        tbl[0] = '{a: 4'h5, cin: 1'b0, b: 4'h3, exp_bus: 9'h053, exp_res: 5'h08};
        tbl[1] = '{a: 4'hF, cin: 1'b1, b: 4'hF, exp_bus: 9'h1FF, exp_res: 5'h1F};
        tbl[2] = '{a: 4'h9, cin: 1'b0, b: 4'h7, exp_bus: 9'h097, exp_res: 5'h10};

        // 1. reset with inputs toggling
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            aif.load     = ~aif.load;
            aif.data_in  = 4'($urandom_range(0, 15));
            aif.cin_in   = 1'($urandom_range(0, 1));
            aif.acc_mode = 1'($urandom_range(0, 1));
        end
        compare_all("reset");
        aif.load = 1'b0; aif.acc_mode = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        compare_all("post_reset");

        // 2/3. table-driven plain adds
        for (int i = 0; i < 3; i++) begin
            do_load(int'(tbl[i].a), int'(tbl[i].cin), 0, $sformatf("tbl%0d_a", i));
            do_load(int'(tbl[i].b), 0, 0, $sformatf("tbl%0d_b", i));
            check($sformatf("tbl%0d.const_bus", i), 32'(aif.operand_bus), 32'(tbl[i].exp_bus));
            check($sformatf("tbl%0d.const_res", i), 32'(aif.result), 32'(tbl[i].exp_res));
        end

        // 4. accumulate chain
        do_load(2, 0, 0, "acc_a");
        do_load(3, 0, 0, "acc_b");
        check("acc.5", 32'(aif.result), 32'h05);
        do_load(4, 0, 1, "acc_4");
        check("acc.9", 32'(aif.result), 32'h09);
        do_load(8, 0, 1, "acc_8");
        check("acc.11", 32'(aif.result), 32'h11);
        do_load(0, 0, 1, "acc_0");
        check("acc.bus", 32'(aif.operand_bus), 32'h110);
        check("acc.02", 32'(aif.result), 32'h02);

        // 5a. load held 50 clk gives one capture
        do_load(6, 0, 0, "hold_a");
        @(negedge clk);
        aif.data_in = 4'd7; aif.cin_in = 1'b0; aif.load = 1'b1;
        repeat (50) @(negedge clk);
        aif.load = 1'b0;
        repeat (4) @(negedge clk);
        model_load(7, 0, 0);
        compare_all("hold50");
        check("hold50.const", 32'(aif.result), 32'h0D);

        // 5b. second edge arrives while settling and is dropped
        do_load(1, 0, 0, "glitch_a");
        @(negedge clk); aif.data_in = 4'd2; aif.load = 1'b1;
        @(negedge clk); aif.load = 1'b0;
        @(negedge clk); aif.load = 1'b1;
        @(negedge clk); aif.load = 1'b0;
        repeat (6) @(negedge clk);
        model_load(2, 0, 0);
        compare_all("glitch");
        check("glitch.const", 32'(aif.result), 32'h03);

        // 6. clear with load during SETTLE aborts
        do_load(3, 0, 0, "abort_a");
        held_res = 32'(aif.result);
        @(negedge clk); aif.data_in = 4'd4; aif.load = 1'b1;
        repeat (3) @(negedge clk);
        check("abort.in_settle", 32'(aif.busy), 32'd1);
        aif.clear = 1'b1;
        @(negedge clk);
        check("abort.state", 32'(aif.state), 32'd0);
        check("abort.vld", 32'(aif.result_valid), 32'd0);
        check("abort.res_held", 32'(aif.result), held_res);
        aif.clear = 1'b0; aif.load = 1'b0;
        repeat (4) @(negedge clk);
        model_clear();
        compare_all("abort");

        // clear beats a simultaneous load pulse
        @(negedge clk); aif.data_in = 4'd9; aif.load = 1'b1;
        repeat (2) @(negedge clk);
        aif.clear = 1'b1;
        @(negedge clk);
        aif.clear = 1'b0;
        repeat (2) @(negedge clk);
        aif.load = 1'b0;
        repeat (4) @(negedge clk);
        compare_all("clear_vs_load");

        // randomized operations against the model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk); aif.clear = 1'b1;
                @(negedge clk); aif.clear = 1'b0;
                model_clear();
                compare_all($sformatf("rnd%0d_clr", i));
            end
            do_load(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        // asynchronous reset mid-operation
        do_load(5, 1, 0, "arst_a");
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        check("arst.state", 32'(aif.state), 32'd0);
        check("arst.bus", 32'(aif.operand_bus), 32'd0);
        check("arst.res", 32'(aif.result), 32'd0);
        check("arst.vld", 32'(aif.result_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
